// File: rtl/jtag_tap_axis_responder.sv
// JTAG target-side responder: oversampled TAP controller with IR, IDCODE, BYPASS and USER
// data registers. Every USER data-register shift is streamed out as AXI-Stream beats
// through a 2-entry output FIFO.
module jtag_tap_axis_responder #(
    parameter int unsigned C_M_AXIS_DATA_WIDTH = 64,
    parameter int unsigned C_IR_LENGTH         = 8,
    parameter logic [31:0] C_IDCODE            = 32'h1BA0_0477,
    parameter logic [7:0]  C_IDCODE_INSTR      = 8'h09,
    parameter logic [7:0]  C_USER_INSTR        = 8'h02
) (
    input  logic                               m_axis_aclk,
    input  logic                               m_axis_aresetn,
    input  logic                               TCK,
    input  logic                               TMS,
    input  logic                               TDI,
    output logic                               TDO,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
    output logic                               m_axis_tvalid,
    input  logic                               m_axis_tready,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic                               m_axis_tlast,
    output logic                               overflow,
    output logic [3:0]                         tap_state
);

    localparam logic [C_IR_LENGTH-1:0] IdcodeOp  = C_IDCODE_INSTR[C_IR_LENGTH-1:0];
    localparam logic [C_IR_LENGTH-1:0] UserOp    = C_USER_INSTR[C_IR_LENGTH-1:0];
    localparam logic [C_IR_LENGTH-1:0] IrCapture = C_IR_LENGTH'(1);

    typedef enum logic [3:0] {
        StTlr   = 4'd0,
        StRti   = 4'd1,
        StSelDr = 4'd2,
        StCapDr = 4'd3,
        StShDr  = 4'd4,
        StEx1Dr = 4'd5,
        StPauDr = 4'd6,
        StEx2Dr = 4'd7,
        StUpdDr = 4'd8,
        StSelIr = 4'd9,
        StCapIr = 4'd10,
        StShIr  = 4'd11,
        StEx1Ir = 4'd12,
        StPauIr = 4'd13,
        StEx2Ir = 4'd14,
        StUpdIr = 4'd15
    } tap_state_e;

    // Synchronizer and edge-detect state
    logic [2:0] tck_sync_q;
    logic [1:0] tms_sync_q;
    logic [1:0] tdi_sync_q;
    logic       tck_rise;
    logic       tck_fall;
    logic       tms_s;
    logic       tdi_s;

    // TAP and register state
    tap_state_e             state_q;
    logic [C_IR_LENGTH-1:0] ir_q;
    logic [C_IR_LENGTH-1:0] ir_shift_q;
    logic [31:0]            dr_q;
    logic                   bypass_q;
    logic [31:0]            acc_q;
    logic [5:0]             cnt_q;
    logic                   tdo_q;

    // Datapath helpers
    logic        idcode_sel;
    logic        user_sel;
    logic        dr_bit;
    logic [7:0]  ir_ext;
    logic [31:0] acc_next;
    logic [5:0]  cnt_next;
    logic        push;
    logic [64:0] push_beat;

    // Output FIFO
    logic [64:0] mem_q [2];
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  level_q;
    logic        overflow_q;
    logic        pop;
    logic        full;
    logic        accept;

    // Two-stage synchronizers; the third TCK stage only serves edge detection
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            tck_sync_q <= '0;
            tms_sync_q <= '0;
            tdi_sync_q <= '0;
        end else begin
            tck_sync_q <= {tck_sync_q[1:0], TCK};
            tms_sync_q <= {tms_sync_q[0], TMS};
            tdi_sync_q <= {tdi_sync_q[0], TDI};
        end
    end

    // Edge detection plus selection and USER capture bookkeeping
    always_comb begin
        tck_rise   = tck_sync_q[1] & ~tck_sync_q[2];
        tck_fall   = ~tck_sync_q[1] & tck_sync_q[2];
        tms_s      = tms_sync_q[1];
        tdi_s      = tdi_sync_q[1];
        idcode_sel = (ir_q == IdcodeOp);
        user_sel   = (ir_q == UserOp) && !idcode_sel;
        dr_bit     = (idcode_sel || user_sel) ? dr_q[0] : bypass_q;
        ir_ext     = '0;
        ir_ext[C_IR_LENGTH-1:0] = ir_q;
        acc_next   = acc_q | ({31'b0, tdi_s} << cnt_q[4:0]);
        cnt_next   = cnt_q + 6'd1;
        // The exit rise (TMS=1) still shifts, so it always flushes at least one bit
        push       = tck_rise && (state_q == StShDr) && user_sel &&
                     ((cnt_next == 6'd32) || tms_s);
        push_beat  = {tms_s, 18'b0, cnt_next, ir_ext, acc_next};
    end

    // TAP controller: standard TMS graph, advanced on each detected TCK rise
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            state_q <= StTlr;
        end else if (tck_rise) begin
            case (state_q)
                StTlr:   state_q <= tms_s ? StTlr   : StRti;
                StRti:   state_q <= tms_s ? StSelDr : StRti;
                StSelDr: state_q <= tms_s ? StSelIr : StCapDr;
                StCapDr: state_q <= tms_s ? StEx1Dr : StShDr;
                StShDr:  state_q <= tms_s ? StEx1Dr : StShDr;
                StEx1Dr: state_q <= tms_s ? StUpdDr : StPauDr;
                StPauDr: state_q <= tms_s ? StEx2Dr : StPauDr;
                StEx2Dr: state_q <= tms_s ? StUpdDr : StShDr;
                StUpdDr: state_q <= tms_s ? StSelDr : StRti;
                StSelIr: state_q <= tms_s ? StTlr   : StCapIr;
                StCapIr: state_q <= tms_s ? StEx1Ir : StShIr;
                StShIr:  state_q <= tms_s ? StEx1Ir : StShIr;
                StEx1Ir: state_q <= tms_s ? StUpdIr : StPauIr;
                StPauIr: state_q <= tms_s ? StEx2Ir : StPauIr;
                StEx2Ir: state_q <= tms_s ? StUpdIr : StShIr;
                StUpdIr: state_q <= tms_s ? StSelDr : StRti;
                default: state_q <= StTlr;
            endcase
        end
    end

    // IR, shift registers and USER accumulator, acted on in the state seen at the TCK rise
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            ir_q       <= IdcodeOp;
            ir_shift_q <= '0;
            dr_q       <= '0;
            bypass_q   <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
        end else begin
            if (state_q == StTlr) begin
                ir_q <= IdcodeOp;
            end
            if (tck_rise) begin
                case (state_q)
                    StCapIr: ir_shift_q <= IrCapture;
                    StShIr:  ir_shift_q <= {tdi_s, ir_shift_q[C_IR_LENGTH-1:1]};
                    // IR is loaded on entry to Update-IR
                    StEx1Ir, StEx2Ir: begin
                        if (tms_s) begin
                            ir_q <= ir_shift_q;
                        end
                    end
                    StCapDr: begin
                        if (idcode_sel) begin
                            dr_q <= C_IDCODE;
                        end else if (user_sel) begin
                            dr_q  <= '0;
                            acc_q <= '0;
                            cnt_q <= '0;
                        end else begin
                            bypass_q <= 1'b0;
                        end
                    end
                    StShDr: begin
                        if (idcode_sel || user_sel) begin
                            dr_q <= {tdi_s, dr_q[31:1]};
                        end else begin
                            bypass_q <= tdi_s;
                        end
                        if (user_sel) begin
                            if (push) begin
                                acc_q <= '0;
                                cnt_q <= '0;
                            end else begin
                                acc_q <= acc_next;
                                cnt_q <= cnt_next;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // TDO changes only on TCK fall while shifting; otherwise it holds
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            tdo_q <= 1'b0;
        end else if (tck_fall) begin
            if (state_q == StShIr) begin
                tdo_q <= ir_shift_q[0];
            end else if (state_q == StShDr) begin
                tdo_q <= dr_bit;
            end
        end
    end

    always_comb begin
        pop    = (level_q != 2'd0) && m_axis_tready;
        full   = (level_q == 2'd2);
        // A full FIFO still takes a push when the head leaves in the same cycle
        accept = push && (!full || pop);
    end

    // 2-entry output FIFO with sticky overflow on a dropped beat
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (accept) begin
                mem_q[wr_ptr_q] <= push_beat;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({accept, pop})
                2'b10:   level_q <= level_q + 2'd1;
                2'b01:   level_q <= level_q - 2'd1;
                default: level_q <= level_q;
            endcase
            if (push && !accept) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_comb begin
        m_axis_tvalid                = (level_q != 2'd0);
        {m_axis_tlast, m_axis_tdata} = mem_q[rd_ptr_q];
        m_axis_tkeep                 = '1;
        overflow                     = overflow_q;
        tap_state                    = state_q;
        TDO                          = tdo_q;
    end

endmodule

// File: tb/tb_jtag_tap_axis_responder.sv
// Bench for jtag_tap_axis_responder: TAP walk table, IDCODE/IR/bypass scans, USER streaming,
// backpressure overflow, reset mid-shift and TLR flush, with a beat scoreboard.
module tb_jtag_tap_axis_responder;

    logic        clk;
    logic        aresetn;
    logic        tck;
    logic        tms;
    logic        tdi;
    logic        tdo;
    logic [63:0] tdata;
    logic        tvalid;
    logic        tready;
    logic [7:0]  tkeep;
    logic        tlast;
    logic        ovf;
    logic [3:0]  tap_state;

    typedef struct {
        logic       tms;
        logic [3:0] st;
    } tap_vec_t;

    typedef struct {
        logic        last;
        logic [63:0] data;
    } beat_t;

    tap_vec_t vecs[$];
    beat_t    exp_q[$];
    int       checks;
    int       errors;
    int       beats_seen;

    jtag_tap_axis_responder dut (
        .m_axis_aclk    (clk),
        .m_axis_aresetn (aresetn),
        .TCK            (tck),
        .TMS            (tms),
        .TDI            (tdi),
        .TDO            (tdo),
        .m_axis_tdata   (tdata),
        .m_axis_tvalid  (tvalid),
        .m_axis_tready  (tready),
        .m_axis_tkeep   (tkeep),
        .m_axis_tlast   (tlast),
        .overflow       (ovf),
        .tap_state      (tap_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic t, input logic [3:0] s);
        tap_vec_t v;
        v.tms = t;
        v.st  = s;
        vecs.push_back(v);
    endtask

    // One TCK period; TDO is sampled just before the rise, as a JTAG master would
    task automatic jtag_bit(input logic t, input logic d, output logic o);
        tms = t;
        tdi = d;
        repeat (6) @(negedge clk);
        o   = tdo;
        tck = 1'b1;
        repeat (6) @(negedge clk);
        tck = 1'b0;
    endtask

    task automatic scan_ir(input logic [7:0] val, output logic [7:0] o);
        logic b;
        o = '0;
        jtag_bit(1'b1, 1'b0, b);
        jtag_bit(1'b1, 1'b0, b);
        jtag_bit(1'b0, 1'b0, b);
        jtag_bit(1'b0, 1'b0, b);
        for (int i = 0; i < 8; i++) begin
            jtag_bit(i == 7, val[i], b);
            o[i] = b;
        end
        jtag_bit(1'b1, 1'b0, b);
        jtag_bit(1'b0, 1'b0, b);
    endtask

    task automatic scan_dr(input int n, input logic [127:0] din, output logic [127:0] o);
        logic b;
        o = '0;
        jtag_bit(1'b1, 1'b0, b);
        jtag_bit(1'b0, 1'b0, b);
        jtag_bit(1'b0, 1'b0, b);
        for (int i = 0; i < n; i++) begin
            jtag_bit(i == n - 1, din[i], b);
            o[i] = b;
        end
        jtag_bit(1'b1, 1'b0, b);
        jtag_bit(1'b0, 1'b0, b);
    endtask

    // Reference model of USER streaming: keeps only the first max_beats beats
    task automatic expect_user(input int n, input logic [127:0] din, input int max_beats,
                               input logic [7:0] ir);
        logic [31:0] acc;
        int          cnt;
        int          pushed;
        beat_t       e;
        acc    = '0;
        cnt    = 0;
        pushed = 0;
        for (int i = 0; i < n; i++) begin
            acc[cnt] = din[i];
            cnt++;
            if (cnt == 32 || i == n - 1) begin
                e.last = (i == n - 1);
                e.data = {18'b0, 6'(cnt), ir, acc};
                if (pushed < max_beats) exp_q.push_back(e);
                pushed++;
                acc = '0;
                cnt = 0;
            end
        end
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d_pending required=0", exp_q.size());
        end
    endtask

    // Scoreboard: pops expected beats on each transfer and checks stall stability
    task automatic monitor();
        logic        pv;
        logic        pr;
        logic        pl;
        logic [63:0] pd;
        beat_t       e;
        pv = 1'b0;
        pr = 1'b0;
        pl = 1'b0;
        pd = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!aresetn) begin
                pv = 1'b0;
            end else begin
                if (pv && !pr) begin
                    checks++;
                    if (!tvalid || tdata !== pd || tlast !== pl) begin
                        errors++;
                        $display("FAIL stall_stable actual=%b/%h/%b required=1/%h/%b",
                                 tvalid, tdata, tlast, pd, pl);
                    end
                end
                if (tvalid && tready) begin
                    beats_seen++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat actual=%h required=none", tdata);
                    end else begin
                        e = exp_q.pop_front();
                        if (tdata !== e.data || tlast !== e.last) begin
                            errors++;
                            $display("FAIL beat actual=%h/%b required=%h/%b",
                                     tdata, tlast, e.data, e.last);
                        end
                    end
                end
                pv = tvalid;
                pr = tready;
                pd = tdata;
                pl = tlast;
            end
        end
    endtask

    initial begin
        logic [7:0]   ir_o;
        logic [127:0] dout;
        logic [127:0] din;
        logic         b;
        int           base;

        checks     = 0;
        errors     = 0;
        beats_seen = 0;
        aresetn    = 1'b0;
        tck        = 1'b0;
        tms        = 1'b0;
        tdi        = 1'b0;
        tready     = 1'b1;

        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        chk("rst_tvalid", 64'(tvalid), 64'd0);
        chk("rst_tlast", 64'(tlast), 64'd0);
        chk("rst_tdata", tdata, 64'd0);
        chk("rst_tdo", 64'(tdo), 64'd0);
        chk("rst_overflow", 64'(ovf), 64'd0);
        chk("rst_tap_state", 64'(tap_state), 64'd0);
        chk("tkeep", 64'(tkeep), 64'hFF);
        aresetn = 1'b1;
        repeat (3) @(negedge clk);

        // TAP graph walk: five TMS=1 then every state once
        for (int i = 0; i < 5; i++) add_vec(1'b1, 4'd0);
        add_vec(1'b0, 4'd1);  add_vec(1'b1, 4'd2);  add_vec(1'b0, 4'd3);
        add_vec(1'b0, 4'd4);  add_vec(1'b1, 4'd5);  add_vec(1'b0, 4'd6);
        add_vec(1'b1, 4'd7);  add_vec(1'b0, 4'd4);  add_vec(1'b1, 4'd5);
        add_vec(1'b1, 4'd8);  add_vec(1'b1, 4'd2);  add_vec(1'b1, 4'd9);
        add_vec(1'b0, 4'd10); add_vec(1'b0, 4'd11); add_vec(1'b1, 4'd12);
        add_vec(1'b0, 4'd13); add_vec(1'b1, 4'd14); add_vec(1'b1, 4'd15);
        add_vec(1'b0, 4'd1);  add_vec(1'b1, 4'd2);  add_vec(1'b1, 4'd9);
        add_vec(1'b1, 4'd0);  add_vec(1'b0, 4'd1);
        foreach (vecs[i]) begin
            jtag_bit(vecs[i].tms, 1'b0, b);
            chk($sformatf("tap_walk_%0d", i), 64'(tap_state), 64'(vecs[i].st));
        end

        // IDCODE scan after TLR
        scan_dr(32, '0, dout);
        chk("idcode", 64'(dout[31:0]), 64'h1BA0_0477);
        chk("rti_after_dr", 64'(tap_state), 64'd1);

        // USER instruction, 40-bit scan with 0xA5 pattern
        scan_ir(8'h02, ir_o);
        chk("ir_capture", 64'(ir_o), 64'h01);
        exp_q.push_back('{1'b0, 64'h0000_2002_A5A5_A5A5});
        exp_q.push_back('{1'b1, 64'h0000_0802_0000_00A5});
        din = {16{8'hA5}};
        scan_dr(40, din, dout);
        wait_drain(50);
        chk("user40_beats", 64'(beats_seen), 64'd2);

        // Bypass: TDO lags TDI by one bit, no beat
        base = beats_seen;
        scan_ir(8'hFF, ir_o);
        chk("ir_capture_ff", 64'(ir_o), 64'h01);
        scan_dr(4, 128'b1101, dout);
        chk("bypass_tdo", 64'(dout[3:0]), 64'b1010);
        repeat (20) @(negedge clk);
        chk("bypass_no_beat", 64'(beats_seen - base), 64'd0);

        // 96 bits with tready low: two beats held, third dropped
        base = beats_seen;
        scan_ir(8'h02, ir_o);
        tready = 1'b0;
        din    = {32'h0, $urandom, $urandom, $urandom};
        expect_user(96, din, 2, 8'h02);
        scan_dr(96, din, dout);
        chk("ovf_set", 64'(ovf), 64'd1);
        chk("ovf_tvalid_held", 64'(tvalid), 64'd1);
        chk("ovf_no_transfer", 64'(beats_seen - base), 64'd0);
        @(negedge clk);
        tready = 1'b1;
        wait_drain(50);
        repeat (20) @(negedge clk);
        chk("ovf_two_beats", 64'(beats_seen - base), 64'd2);
        chk("ovf_sticky", 64'(ovf), 64'd1);

        // Reset after 10 bits of a USER shift
        base = beats_seen;
        scan_ir(8'h02, ir_o);
        jtag_bit(1'b1, 1'b0, b);
        jtag_bit(1'b0, 1'b0, b);
        jtag_bit(1'b0, 1'b0, b);
        for (int i = 0; i < 10; i++) jtag_bit(1'b0, 1'($urandom_range(0, 1)), b);
        chk("pre_rst_state", 64'(tap_state), 64'd4);
        @(negedge clk);
        aresetn = 1'b0;
        #1;
        chk("mid_rst_tvalid", 64'(tvalid), 64'd0);
        chk("mid_rst_tdata", tdata, 64'd0);
        chk("mid_rst_tlast", 64'(tlast), 64'd0);
        chk("mid_rst_overflow", 64'(ovf), 64'd0);
        chk("mid_rst_state", 64'(tap_state), 64'd0);
        chk("mid_rst_tdo", 64'(tdo), 64'd0);
        repeat (3) @(negedge clk);
        aresetn = 1'b1;
        repeat (30) @(negedge clk);
        chk("post_rst_no_beat", 64'(beats_seen - base), 64'd0);
        chk("post_rst_tvalid", 64'(tvalid), 64'd0);

        // Five TMS=1 from Shift-DR: exit rise flushes 6 bits, then TLR restores IDCODE
        base = beats_seen;
        jtag_bit(1'b0, 1'b0, b);
        scan_ir(8'h02, ir_o);
        jtag_bit(1'b1, 1'b0, b);
        jtag_bit(1'b0, 1'b0, b);
        jtag_bit(1'b0, 1'b0, b);
        exp_q.push_back('{1'b1, 64'h0000_0602_0000_002B});
        jtag_bit(1'b0, 1'b1, b);
        jtag_bit(1'b0, 1'b1, b);
        jtag_bit(1'b0, 1'b0, b);
        jtag_bit(1'b0, 1'b1, b);
        jtag_bit(1'b0, 1'b0, b);
        jtag_bit(1'b1, 1'b1, b);
        for (int i = 0; i < 4; i++) jtag_bit(1'b1, 1'b0, b);
        chk("flush_tlr", 64'(tap_state), 64'd0);
        wait_drain(50);
        chk("flush_one_beat", 64'(beats_seen - base), 64'd1);
        jtag_bit(1'b0, 1'b0, b);
        scan_dr(32, '0, dout);
        chk("idcode_after_tlr", 64'(dout[31:0]), 64'h1BA0_0477);
        repeat (20) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
